// File: rtl/mmio_console.sv
// mmio_console: console and exit device on the core's data-memory write port.
// Bytes written to PUTC_ADDR are queued and sent as 8N1 UART frames.
// A write to EXIT_ADDR latches the exit code. exit_req rises once the line has drained.
module mmio_console #(
   parameter logic [31:0] PUTC_ADDR  = 32'h9000001C,
   parameter logic [31:0] EXIT_ADDR  = 32'h9000002C,
   parameter int          FIFO_DEPTH = 16,
   parameter int          CLKDIV     = 868
) (
   input  logic                        clk,
   input  logic                        resetb,
   input  logic                        dmem_wready,
   output logic                        dmem_wvalid,
   input  logic [31:0]                 dmem_waddr,
   input  logic [31:0]                 dmem_wdata,
   input  logic [3:0]                  dmem_wstrb,
   output logic                        mmio_hit,
   output logic                        uart_tx,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        exit_req,
   output logic [31:0]                 exit_code
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = $clog2(CLKDIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
   localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_t;

   tx_state_t      state;
   logic [DW-1:0]  divcnt;
   logic [2:0]     bitcnt;
   logic [7:0]     shreg;
   logic           exit_pending;
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [7:0]     mem [FIFO_DEPTH];
   logic           fifo_full;
   logic           fifo_empty;
   logic           putc_hit;
   logic           exit_hit;
   logic           wr_fire;
   logic           push;
   logic           pop;
   logic           unused_strb;

   // Byte lanes are not used: the PUTC character always comes from lane 0.
   assign unused_strb = ^dmem_wstrb;

   assign putc_hit    = (dmem_waddr == PUTC_ADDR);
   assign exit_hit    = (dmem_waddr == EXIT_ADDR);
   assign mmio_hit    = putc_hit | exit_hit;

   assign fifo_level  = wr_ptr - rd_ptr;
   assign fifo_full   = (fifo_level == DEPTH);
   assign fifo_empty  = (fifo_level == '0);

   // Back-pressure comes only from a full queue. It is based on registered state,
   // so a pop on the same edge does not let an extra write through.
   assign dmem_wvalid = !(putc_hit && fifo_full);
   assign wr_fire     = dmem_wready && dmem_wvalid;
   assign push        = wr_fire && putc_hit && !exit_pending;
   assign pop         = (state == S_IDLE) && !fifo_empty;
   assign tx_busy     = (state != S_IDLE);

   // Character storage. It has no reset because occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= dmem_wdata[7:0];
      end
   end

   // Wrap-around read/write pointers. Each is one bit wider than the address,
   // so that full and empty can be told apart.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Exit handling: latch the first exit code, then signal once the line is drained.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         exit_pending <= 1'b0;
         exit_code    <= '0;
         exit_req     <= 1'b0;
      end else begin
         if (wr_fire && exit_hit && !exit_pending) begin
            exit_pending <= 1'b1;
            exit_code    <= dmem_wdata;
         end
         if (exit_pending && fifo_empty && (state == S_IDLE)) begin
            exit_req <= 1'b1;
         end
      end
   end

   // 8N1 serializer. The line is registered and each bit is held for CLKDIV cycles.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state   <= S_IDLE;
         divcnt  <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         uart_tx <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  shreg   <= mem[rd_ptr[AW-1:0]];
                  uart_tx <= 1'b0;
                  divcnt  <= '0;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (divcnt == DIV_LAST) begin
                  divcnt  <= '0;
                  bitcnt  <= '0;
                  uart_tx <= shreg[0];
                  state   <= S_DATA;
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            S_DATA: begin
               if (divcnt == DIV_LAST) begin
                  divcnt <= '0;
                  if (bitcnt == 3'd7) begin
                     uart_tx <= 1'b1;
                     state   <= S_STOP;
                  end else begin
                     shreg   <= {1'b0, shreg[7:1]};
                     uart_tx <= shreg[1];
                     bitcnt  <= bitcnt + 1'b1;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            S_STOP: begin
               if (divcnt == DIV_LAST) begin
                  divcnt <= '0;
                  state  <= S_IDLE;
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
